// File: rtl/phase_correct_pwm_pkg.sv
// phase_correct_pwm_pkg: shared width default and counter direction type
package phase_correct_pwm_pkg;
  localparam int PWM_WIDTH = 32;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: double-buffered compare and registered center-aligned output
module pwm_channel
  import phase_correct_pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt,
  input  dir_t             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] cmp_in,
  output logic             pwm
);
  logic [WIDTH-1:0] cmp_s;
  always_ff @(posedge clk) begin
    if (reset) begin
      cmp_s <= cmp_in;
      pwm   <= 1'b0;
    end else begin
      pwm <= (dir == DIR_UP) ? (cnt < cmp_s) : (cnt <= cmp_s);
      if (load) cmp_s <= cmp_in;
    end
  end
endmodule

// File: rtl/phase_correct_pwm.sv
// phase_correct_pwm: up/down counter with TOP shadow driving two PWM channels
module phase_correct_pwm
  import phase_correct_pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] top,
  input  logic [WIDTH-1:0] pwm_a,
  input  logic [WIDTH-1:0] pwm_b,
  output logic             pwm_outa,
  output logic             pwm_outb
);
  logic [WIDTH-1:0] cnt, top_s;
  dir_t dir;
  logic load;
  // shadows refresh on the edge that lands on BOTTOM, or every cycle while TOP is 0
  assign load = reset || (top_s == '0) || (dir == DIR_DOWN && cnt == WIDTH'(1));
  always_ff @(posedge clk) begin
    if (reset || top_s == '0) begin
      cnt   <= '0;
      dir   <= DIR_UP;
      top_s <= top;
    end else if (dir == DIR_UP) begin
      cnt <= cnt + WIDTH'(1);
      if (cnt == top_s - WIDTH'(1)) dir <= DIR_DOWN;
    end else begin
      cnt <= cnt - WIDTH'(1);
      if (cnt == WIDTH'(1)) begin
        dir   <= DIR_UP;
        top_s <= top;
      end
    end
  end
  pwm_channel #(.WIDTH(WIDTH)) u_a (
    .clk(clk), .reset(reset), .cnt(cnt), .dir(dir), .load(load), .cmp_in(pwm_a), .pwm(pwm_outa)
  );
  pwm_channel #(.WIDTH(WIDTH)) u_b (
    .clk(clk), .reset(reset), .cnt(cnt), .dir(dir), .load(load), .cmp_in(pwm_b), .pwm(pwm_outb)
  );
endmodule

// File: tb/tb_phase_correct_pwm.sv
// tb_phase_correct_pwm: phase-based reference model feeding a scoreboard for a 32-bit and an 8-bit instance
module tb_phase_correct_pwm;
  bit clk;
  always #5 clk = ~clk;
  logic        reset;
  logic [31:0] top, pwm_a, pwm_b;
  logic [7:0]  top8, a8, b8;
  logic        oa, ob, oa8, ob8;
  logic [3:0]  sb[$];
  int          checks, errors, cyc;
  longint      m_t[2], m_ca[2], m_cb[2], m_ph[2];

  phase_correct_pwm dut (
    .clk(clk), .reset(reset), .top(top), .pwm_a(pwm_a), .pwm_b(pwm_b),
    .pwm_outa(oa), .pwm_outb(ob)
  );
  phase_correct_pwm #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .top(top8), .pwm_a(a8), .pwm_b(b8),
    .pwm_outa(oa8), .pwm_outb(ob8)
  );

  // a period is 2T phases starting at BOTTOM; a channel is high for the first C and last C phases
  function automatic bit hi(longint ph, longint c, longint t);
    if (t == 0) return c > 0;
    return (ph < c) || (ph >= 2 * t - c);
  endfunction

  task automatic step();
    longint it[2], ia[2], ib[2];
    logic [3:0] e;
    it[0] = top;  ia[0] = pwm_a; ib[0] = pwm_b;
    it[1] = top8; ia[1] = a8;    ib[1] = b8;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        e[2*k] = 1'b0; e[2*k+1] = 1'b0;
        m_ph[k] = 0;
      end else begin
        e[2*k]   = hi(m_ph[k], m_ca[k], m_t[k]);
        e[2*k+1] = hi(m_ph[k], m_cb[k], m_t[k]);
        m_ph[k]  = (m_t[k] == 0) ? 0 : (m_ph[k] + 1) % (2 * m_t[k]);
      end
      if (m_ph[k] == 0) begin
        m_t[k] = it[k]; m_ca[k] = ia[k]; m_cb[k] = ib[k];
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({ob8, oa8, ob, oa} !== e) begin
          errors++;
          $display("FAIL outs cycle %0d got {b8,a8,b,a}=%b exp %b", cyc, {ob8, oa8, ob, oa}, e);
        end
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1;
    top = 100; pwm_a = 50; pwm_b = 30;
    top8 = 8'hFF; a8 = 8'd200; b8 = 8'hFF;
    do_reset();
    run(450);
    top = 10; pwm_a = 0; pwm_b = 10;
    do_reset();
    run(60);
    pwm_b = 15;
    run(60);
    top = 20; pwm_a = 5;
    do_reset();
    run(12);
    pwm_a = 15; top = 8;
    run(80);
    top = 0; pwm_a = 1;
    do_reset();
    run(30);
    pwm_a = 0;
    run(30);
    top = 1; pwm_a = 1;
    run(30);
    top = 50; pwm_a = 25; pwm_b = 50;
    do_reset();
    run(60);
    do_reset();
    run(120);
    top8 = 8'hF0; a8 = 8'hF0; b8 = 8'h80;
    run(1100);
    for (int r = 0; r < 25; r++) begin
      top   = $urandom_range(0, 40);
      pwm_a = $urandom_range(0, top + 3);
      pwm_b = $urandom_range(0, top + 3);
      top8  = 8'($urandom_range(0, 255));
      a8    = 8'($urandom_range(0, 255));
      b8    = 8'($urandom_range(0, 255));
      n = $urandom_range(20, 150);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 15) == 0) pwm_a = $urandom_range(0, top + 3);
        if ($urandom_range(0, 30) == 0) top = $urandom_range(0, 40);
        reset = ($urandom_range(0, 80) == 0);
        step();
      end
      reset = 1'b0;
    end
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
